// File: rtl/fetch_resp_buf_if.sv
// Fetch-path bundle: PC request, icache read/response and decode hand-off.
// The buffer takes the slave side; PC stage, icache and decode drive the master side.
interface fetch_resp_buf_if;
  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] req_pc;
  logic            req_valid;
  logic            req_ready;
  logic            flush;
  logic            icache_re;
  logic [XLEN-1:0] icache_addr;
  logic            icache_resp_valid;
  logic [XLEN-1:0] icache_dout;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;

  modport master (
    output req_pc, req_valid, flush, icache_resp_valid, icache_dout, out_ready,
    input  req_ready, icache_re, icache_addr, out_valid, out_pc, out_inst
  );

  modport slave (
    input  req_pc, req_valid, flush, icache_resp_valid, icache_dout, out_ready,
    output req_ready, icache_re, icache_addr, out_valid, out_pc, out_inst
  );
endinterface

// File: rtl/fetch_resp_buf.sv
// Fetch response buffer: pairs in-order icache responses with their PCs for decode.
// Optional FETCH_BYPASS_EN forwards a response to decode in its arrival cycle.
module fetch_resp_buf #(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  fetch_resp_buf_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned XLEN  = 32;

  logic [PTR_W-1:0] alloc_ptr, fill_ptr, head_ptr, drop_cnt;
  logic [PTR_W-1:0] alloc_ptr_nxt, fill_ptr_nxt, head_ptr_nxt, drop_cnt_nxt;
  logic [XLEN-1:0]  slot_pc   [DEPTH];
  logic [XLEN-1:0]  slot_inst [DEPTH];
  logic [DEPTH-1:0] slot_filled;

  logic [PTR_W-1:0] occupancy, in_flight;
  logic [IDX_W-1:0] head_idx, fill_idx, alloc_idx;
  logic [CNT_W-1:0] used, drop_sum;
  logic             accept, resp_keep, resp_drop, pop, head_filled, bypass_hit, write_fill;

  // Slot bookkeeping derived from the three pointers
  assign occupancy   = alloc_ptr - head_ptr;
  assign in_flight   = alloc_ptr - fill_ptr;
  assign head_idx    = head_ptr[IDX_W-1:0];
  assign fill_idx    = fill_ptr[IDX_W-1:0];
  assign alloc_idx   = alloc_ptr[IDX_W-1:0];
  assign head_filled = slot_filled[head_idx];
  assign used        = CNT_W'(occupancy) + CNT_W'(drop_cnt);

  // Ready counts slots still owed a discarded response, so it never depends on out_ready
  assign bus.req_ready   = !bus.flush && (used < CNT_W'(DEPTH));
  assign accept          = bus.req_valid && bus.req_ready && reset_n;
  assign bus.icache_re   = accept;
  assign bus.icache_addr = bus.req_pc;

  assign resp_drop = bus.icache_resp_valid && (drop_cnt != '0);
  assign resp_keep = bus.icache_resp_valid && (drop_cnt == '0) && (fill_ptr != alloc_ptr);

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = (occupancy == PTR_W'(1)) && !head_filled && (drop_cnt == '0)
                      && bus.icache_resp_valid;
`else
  assign bypass_hit = 1'b0;
`endif

  assign bus.out_valid = ((occupancy != '0) && head_filled) || bypass_hit;
  assign bus.out_pc    = slot_pc[head_idx];
  assign bus.out_inst  = bypass_hit ? bus.icache_dout : slot_inst[head_idx];

  assign pop        = bus.out_valid && bus.out_ready && !bus.flush;
  // A bypassed response that is consumed immediately never lands in the slot
  assign write_fill = resp_keep && !bus.flush && !(bypass_hit && pop);

  // Pointer and drop-counter next state; flush collapses the ring onto alloc_ptr
  always_comb begin
    alloc_ptr_nxt = alloc_ptr + PTR_W'(accept);
    head_ptr_nxt  = head_ptr + PTR_W'(pop);
    fill_ptr_nxt  = fill_ptr + PTR_W'(resp_keep);
    drop_cnt_nxt  = drop_cnt - PTR_W'(resp_drop);
    drop_sum      = CNT_W'(drop_cnt) + CNT_W'(in_flight);
    if (bus.flush) begin
      alloc_ptr_nxt = alloc_ptr;
      head_ptr_nxt  = alloc_ptr;
      fill_ptr_nxt  = alloc_ptr;
      if (bus.icache_resp_valid && (drop_sum != '0)) begin
        drop_sum = drop_sum - CNT_W'(1);
      end
      drop_cnt_nxt = PTR_W'(drop_sum);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      drop_cnt  <= '0;
    end else begin
      alloc_ptr <= alloc_ptr_nxt;
      fill_ptr  <= fill_ptr_nxt;
      head_ptr  <= head_ptr_nxt;
      drop_cnt  <= drop_cnt_nxt;
    end
  end

  // Slot storage: accept, fill and pop always touch distinct slots
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_filled <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot_pc[i]   <= '0;
        slot_inst[i] <= '0;
      end
    end else if (bus.flush) begin
      slot_filled <= '0;
    end else begin
      if (pop) begin
        slot_filled[head_idx] <= 1'b0;
      end
      if (write_fill) begin
        slot_inst[fill_idx]   <= bus.icache_dout;
        slot_filled[fill_idx] <= 1'b1;
      end
      if (accept) begin
        slot_pc[alloc_idx]     <= bus.req_pc;
        slot_filled[alloc_idx] <= 1'b0;
      end
    end
  end

  resp_without_req_a: assert property (@(posedge clk) disable iff (!reset_n)
    bus.icache_resp_valid |-> ((drop_cnt != '0) || (fill_ptr != alloc_ptr)));

endmodule

// File: tb/tb_fetch_resp_buf.sv
// Bench for fetch_resp_buf: queue-based reference model, in-order icache model and
// randomized traffic, plus directed fetch/fill/flush/wrap/async-reset scenarios.
module tb_fetch_resp_buf;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fetch_resp_buf_if bus();
  fetch_resp_buf #(.DEPTH(DEPTH)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model: outstanding fetches in order, filled ones form a prefix
  logic [31:0] m_pc[$];
  logic [31:0] m_inst[$];
  int          nf   = 0;
  int          drop = 0;

  // Icache model: strictly in-order responses, each no earlier than its due cycle
  logic [31:0] ic_pc[$];
  int          ic_due[$];
  int          lat_next = 1;
  bit          lat_rand = 1'b0;

  logic [31:0] acc_pc[$];
  logic [31:0] del_pc[$];
  logic [31:0] del_inst[$];
  logic        obs_valid, obs_ready;
  logic [31:0] obs_pc, obs_inst;

  function automatic logic [31:0] ic_inst(input logic [31:0] pc);
    return 32'h0000_0013 ^ (pc - 32'h2000);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cycle);
    end
  endtask

  // Per-cycle compare against the model, then advance the model past the coming edge
  always @(negedge clk) begin : compare
    int sz, d;
    bit exp_ready, exp_re, byp, exp_valid, pop, resp;
    if (!reset_n) begin
      m_pc.delete(); m_inst.delete(); nf = 0; drop = 0;
      ic_pc.delete(); ic_due.delete();
    end else begin
      sz        = m_pc.size();
      resp      = bus.icache_resp_valid;
      exp_ready = !bus.flush && (sz + drop < DEPTH);
      exp_re    = bus.req_valid && exp_ready;
      byp       = 1'b0;
`ifdef FETCH_BYPASS_EN
      byp = (sz == 1) && (nf == 0) && (drop == 0) && resp;
`endif
      exp_valid = (nf > 0) || byp;
      obs_valid = bus.out_valid;
      obs_ready = bus.req_ready;
      obs_pc    = bus.out_pc;
      obs_inst  = bus.out_inst;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      chk("icache_re", 32'(bus.icache_re), 32'(exp_re));
      if (exp_re) chk("icache_addr", bus.icache_addr, bus.req_pc);
      chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("out_pc", bus.out_pc, m_pc[0]);
        chk("out_inst", bus.out_inst, byp ? bus.icache_dout : m_inst[0]);
      end
      if (bus.out_valid && bus.out_ready && !bus.flush) begin
        del_pc.push_back(bus.out_pc);
        del_inst.push_back(bus.out_inst);
      end
      pop = exp_valid && bus.out_ready && !bus.flush;
      if (bus.flush) begin
        d = drop + (sz - nf) - (resp ? 1 : 0);
        drop = (d < 0) ? 0 : d;
        m_pc.delete(); m_inst.delete(); nf = 0;
      end else begin
        if (resp) begin
          if (drop > 0) drop--;
          else if (!(byp && pop) && nf < sz) begin
            m_inst.push_back(bus.icache_dout);
            nf++;
          end
        end
        if (pop) begin
          void'(m_pc.pop_front());
          if (nf > 0) begin
            void'(m_inst.pop_front());
            nf--;
          end
        end
      end
      if (resp && ic_pc.size() > 0) begin
        void'(ic_pc.pop_front());
        void'(ic_due.pop_front());
      end
      if (exp_re) begin
        m_pc.push_back(bus.req_pc);
        acc_pc.push_back(bus.req_pc);
        ic_pc.push_back(bus.req_pc);
        ic_due.push_back(cycle + (lat_rand ? int'($urandom_range(4, 1)) : lat_next));
      end
    end
    cycle++;
  end

  // One bench cycle: present the icache response, let the DUT clock once
  task automatic cyc();
    if (ic_pc.size() > 0 && ic_due[0] <= cycle) begin
      bus.icache_resp_valid = 1'b1;
      bus.icache_dout       = ic_inst(ic_pc[0]);
    end else begin
      bus.icache_resp_valid = 1'b0;
      bus.icache_dout       = $urandom;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int k = 0;
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    while ((ic_pc.size() != 0 || m_pc.size() != 0 || drop != 0) && k < 200) begin
      cyc();
      k++;
    end
    chk(name, 32'(k < 200), 32'd1);
  endtask

  task automatic wait_del(input int n, input string name);
    int k = 0;
    while (del_pc.size() < n && k < 300) begin
      cyc();
      k++;
    end
    chk(name, 32'(del_pc.size() >= n), 32'd1);
  endtask

  task automatic random_run(input int n);
    bit prev_flush = 1'b0;
    lat_rand = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.req_valid = ($urandom % 4) != 0;
      bus.req_pc    = $urandom & 32'hFFFF_FFFC;
      bus.out_ready = ($urandom % 3) != 0;
      bus.flush     = !prev_flush && (($urandom % 20) == 0);
      prev_flush    = bus.flush;
      cyc();
    end
    drain("random_drain");
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin : stim
    int t0, k;
    reset_n = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_pc = 32'h0000_0040;
    bus.flush = 1'b0;
    bus.icache_resp_valid = 1'b0;
    bus.icache_dout = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("re_in_reset", 32'(bus.icache_re), 32'd0);
    bus.req_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    chk("rst_out_inst", bus.out_inst, 32'd0);

    // Single fetch, response two cycles after accept
    lat_rand = 1'b0; lat_next = 2; bus.out_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_pc = 32'h2000; cyc();
    bus.req_valid = 1'b0; cyc();
    chk("single_pre_resp", 32'(obs_valid), 32'd0);
    cyc();
`ifdef FETCH_BYPASS_EN
    chk("single_bypass_valid", 32'(obs_valid), 32'd1);
    chk("single_bypass_pc", obs_pc, 32'h2000);
    chk("single_bypass_inst", obs_inst, 32'h13);
`else
    chk("single_resp_cycle", 32'(obs_valid), 32'd0);
    cyc();
    chk("single_valid", 32'(obs_valid), 32'd1);
    chk("single_pc", obs_pc, 32'h2000);
    chk("single_inst", obs_inst, 32'h13);
`endif
    cyc();
    chk("single_popped", 32'(obs_valid), 32'd0);
    drain("single_drain");

    // Fill all slots with decode stalled
    del_pc.delete(); del_inst.delete();
    lat_next = 1; bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'b1; bus.req_pc = 32'(4 * i); cyc();
    end
    bus.req_valid = 1'b0; cyc();
    chk("fill_full_ready", 32'(obs_ready), 32'd0);
    cyc();
    bus.out_ready = 1'b1; cyc();
    chk("fill_pop_cycle_ready", 32'(obs_ready), 32'd0);
    chk("fill_head_pc", obs_pc, 32'h0);
    bus.out_ready = 1'b0; cyc();
    chk("fill_ready_after_pop", 32'(obs_ready), 32'd1);
    bus.out_ready = 1'b1;
    wait_del(4, "fill_deliver");
    for (int i = 0; i < 4; i++)
      chk("fill_order", (del_pc.size() > i) ? del_pc[i] : 32'hDEAD_BEEF, 32'(4 * i));
    drain("fill_drain");

    // Flush with one buffered and two in flight
    del_pc.delete(); del_inst.delete();
    bus.out_ready = 1'b0;
    lat_next = 1; bus.req_valid = 1'b1; bus.req_pc = 32'h40; cyc();
    lat_next = 6; bus.req_pc = 32'h44; cyc();
    bus.req_pc = 32'h48; cyc();
    bus.req_valid = 1'b0; bus.flush = 1'b1; cyc();
    bus.flush = 1'b0;
    chk("flush_drop_cnt", 32'(dut.drop_cnt), 32'd2);
    cyc();
    chk("flush_out_valid", 32'(obs_valid), 32'd0);
    bus.out_ready = 1'b1; lat_next = 1;
    bus.req_valid = 1'b1; bus.req_pc = 32'h100; cyc();
    bus.req_valid = 1'b0;
    wait_del(1, "flush_deliver");
    repeat (10) cyc();
    chk("flush_count", 32'(del_pc.size()), 32'd1);
    chk("flush_first_pc", (del_pc.size() > 0) ? del_pc[0] : 32'hDEAD_BEEF, 32'h100);
    chk("flush_first_inst", (del_inst.size() > 0) ? del_inst[0] : 32'hDEAD_BEEF, ic_inst(32'h100));
    drain("flush_drain");

    // Flush coinciding with a response, two in flight
    del_pc.delete(); del_inst.delete();
    t0 = cycle;
    lat_next = 3; bus.req_valid = 1'b1; bus.req_pc = 32'h200; cyc();
    lat_next = 5; bus.req_pc = 32'h204; cyc();
    bus.req_valid = 1'b0;
    while (cycle < t0 + 3) cyc();
    bus.flush = 1'b1; cyc();
    bus.flush = 1'b0;
    chk("flush_resp_drop_cnt", 32'(dut.drop_cnt), 32'd1);
    lat_next = 1; bus.req_valid = 1'b1; bus.req_pc = 32'h300; cyc();
    bus.req_valid = 1'b0;
    wait_del(1, "flush_resp_deliver");
    repeat (8) cyc();
    chk("flush_resp_count", 32'(del_pc.size()), 32'd1);
    chk("flush_resp_first_pc", (del_pc.size() > 0) ? del_pc[0] : 32'hDEAD_BEEF, 32'h300);
    drain("flush_resp_drain");

    // Twenty back-to-back fetches across pointer wrap, random decode stalls
    del_pc.delete(); del_inst.delete(); acc_pc.delete();
    lat_rand = 1'b1; k = 0;
    while (acc_pc.size() < 20 && k < 400) begin
      bus.req_valid = 1'b1;
      bus.req_pc    = 32'h1000 + 32'(4 * acc_pc.size());
      bus.out_ready = $urandom % 2;
      cyc();
      k++;
    end
    bus.req_valid = 1'b0; bus.out_ready = 1'b1;
    wait_del(20, "wrap_deliver");
    chk("wrap_count", 32'(del_pc.size()), 32'd20);
    for (int i = 0; i < 20; i++) begin
      chk("wrap_pc", (del_pc.size() > i) ? del_pc[i] : 32'hDEAD_BEEF, 32'h1000 + 32'(4 * i));
      chk("wrap_inst", (del_inst.size() > i) ? del_inst[i] : 32'hDEAD_BEEF,
          ic_inst(32'h1000 + 32'(4 * i)));
    end
    drain("wrap_drain");

    random_run(400);

    // Async reset mid-stream with drops pending and buffer full
    lat_rand = 1'b0; lat_next = 8; bus.out_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_pc = 32'h500; cyc();
    bus.req_pc = 32'h504; cyc();
    bus.req_valid = 1'b0; bus.flush = 1'b1; cyc();
    bus.flush = 1'b0;
    bus.req_valid = 1'b1; bus.req_pc = 32'h600; cyc();
    bus.req_pc = 32'h604; cyc();
    bus.req_valid = 1'b0; cyc();
    chk("pre_reset_ready", 32'(obs_ready), 32'd0);
    #2;
    bus.icache_resp_valid = 1'b0;
    bus.out_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    #1;
    chk("post_rst_drop_cnt", 32'(dut.drop_cnt), 32'd0);
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    random_run(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
